// File: rtl/int_gen_dev.sv
// Memory-mapped interrupt source: raises interrupt on a PC match or a countdown expiry
// and holds it until software acknowledges with a write to BASE+0.
module int_gen_dev #(
    parameter logic [31:0] BASE  = 32'h0000_7f20,
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] macroscopic_pc,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    input  logic [31:0] m_int_wdata,
    output logic [31:0] m_int_rdata,
    output logic        interrupt,
    output logic [7:0]  irq_count
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StAssert = 2'd2,
        StDone   = 2'd3
    } state_e;

    state_e           state_q;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] cnt_q;
    logic             int_q;
    logic [7:0]       irq_cnt_q;

    logic        hit, wr_en, ack, ctrl_wr, tgt_wr, pre_wr, fire;
    logic [1:0]  sel;
    logic [31:0] tgt_merged, pre_merged;

    assign hit     = (m_int_addr & ~32'hF) == BASE;
    assign sel     = m_int_addr[3:2];
    assign wr_en   = hit && (m_int_byteen != 4'b0000);
    assign ack     = wr_en && (sel == 2'd0);
    assign ctrl_wr = wr_en && (sel == 2'd1);
    assign tgt_wr  = wr_en && (sel == 2'd2);
    assign pre_wr  = wr_en && (sel == 2'd3);

    always_comb begin
        ctrl_d     = ctrl_q;
        tgt_merged = target_q;
        pre_merged = 32'(preset_q);
        if (ctrl_wr && m_int_byteen[0]) begin
            ctrl_d = m_int_wdata[2:0];
        end
        for (int b = 0; b < 4; b++) begin
            if (m_int_byteen[b]) begin
                tgt_merged[8*b +: 8] = m_int_wdata[8*b +: 8];
                pre_merged[8*b +: 8] = m_int_wdata[8*b +: 8];
            end
        end
        target_d = tgt_wr ? {tgt_merged[31:2], 2'b00} : target_q;
        preset_d = pre_wr ? pre_merged[CNT_W-1:0] : preset_q;
    end

    // MODE selects countdown expiry over PC match
    assign fire = ctrl_q[1] ? (cnt_q == '0)
                            : ((macroscopic_pc & ~32'h3) == target_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= 3'b000;
            target_q <= 32'h0;
            preset_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            target_q <= target_d;
            preset_q <= preset_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            int_q     <= 1'b0;
            irq_cnt_q <= 8'h00;
        end else if (!ctrl_q[0] || (ctrl_wr && !ctrl_d[0])) begin
            // A write clearing EN drops the request on the write edge itself
            state_q <= StIdle;
            int_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StArmed;
                    cnt_q   <= preset_q;
                end
                StArmed: begin
                    if (fire) begin
                        int_q   <= 1'b1;
                        state_q <= StAssert;
                        if (irq_cnt_q != 8'hFF) begin
                            irq_cnt_q <= irq_cnt_q + 8'd1;
                        end
                    end else if (ctrl_q[1]) begin
                        cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                StAssert: begin
                    if (ack) begin
                        int_q <= 1'b0;
                        if (ctrl_q[2]) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StArmed;
                            cnt_q   <= preset_q;
                        end
                    end
                end
                StDone: begin
                    if (ctrl_wr) begin
                        state_q <= StArmed;
                        cnt_q   <= preset_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        m_int_rdata = 32'h0;
        if (hit) begin
            unique case (sel)
                2'd0: m_int_rdata = {20'b0, state_q, 1'b0, int_q, irq_cnt_q};
                2'd1: m_int_rdata = {29'b0, ctrl_q};
                2'd2: m_int_rdata = target_q;
                2'd3: m_int_rdata = 32'(preset_q);
                default: m_int_rdata = 32'h0;
            endcase
        end
    end

    assign interrupt = int_q;
    assign irq_count = irq_cnt_q;

endmodule

// File: tb/tb_int_gen_dev.sv
// Scoreboard bench for int_gen_dev: stimulus queues expected reads and interrupt rise
// cycles; a negedge monitor pops and compares them.
module tb_int_gen_dev;

    localparam logic [31:0] A_ACK = 32'h7f20;
    localparam logic [31:0] A_CTL = 32'h7f24;
    localparam logic [31:0] A_TGT = 32'h7f28;
    localparam logic [31:0] A_PRE = 32'h7f2C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h3028;
    logic [31:0] addr = 32'h0;
    logic [3:0]  byteen = 4'b0000;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        interrupt;
    logic [7:0]  irq_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_int = 1'b0;

    string       name_q[$];
    int          kind_q[$];
    logic [31:0] exp_q[$];
    int          rise_q[$];

    int_gen_dev dut (
        .clk           (clk),
        .reset         (reset),
        .macroscopic_pc(pc),
        .m_int_addr    (addr),
        .m_int_byteen  (byteen),
        .m_int_wdata   (wdata),
        .m_int_rdata   (rdata),
        .interrupt     (interrupt),
        .irq_count     (irq_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a;
        byteen = be;
        wdata = d;
        step();
        byteen = 4'b0000;
    endtask

    // kind 0 = rdata at address a, 1 = interrupt, 2 = irq_count
    task automatic expect_out(input string n, input int kind, input logic [31:0] a,
                              input logic [31:0] e);
        if (kind == 0) addr = a;
        name_q.push_back(n);
        kind_q.push_back(kind);
        exp_q.push_back(e);
        step();
    endtask

    task automatic expect_rise(input int edges_ahead);
        rise_q.push_back(cyc + edges_ahead);
    endtask

    initial begin : monitor
        string       n;
        int          k;
        logic [31:0] e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (kind_q.size() > 0) begin
                n = name_q.pop_front();
                k = kind_q.pop_front();
                e = exp_q.pop_front();
                case (k)
                    0:       act = rdata;
                    1:       act = {31'b0, interrupt};
                    default: act = {24'b0, irq_count};
                endcase
                cmp(n, act, e);
            end
            if (interrupt && !prev_int) begin
                if (rise_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_irq: rise at cycle %0d, none required", cyc);
                end else begin
                    cmp("irq_rise_cycle", 32'(cyc), 32'(rise_q.pop_front()));
                end
            end
            prev_int = interrupt;
        end
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        expect_out("rst_status", 0, A_ACK, 32'h0);
        expect_out("rst_ctrl",   0, A_CTL, 32'h0);
        expect_out("rst_irq",    1, 0, 32'h0);

        // PC match, repeat mode
        wr(A_TGT, 4'hF, 32'h302C);
        wr(A_CTL, 4'hF, 32'h1);
        step();
        step();
        expect_out("armed_status", 0, A_ACK, 32'h400);
        pc = 32'h302C;
        expect_rise(1);
        step();
        expect_out("fire1_status", 0, A_ACK, 32'h901);

        // Ack returns to ARMED, then oneshot goes to DONE
        pc = 32'h3028;
        wr(A_ACK, 4'b0001, 32'h0);
        expect_out("ack_status", 0, A_ACK, 32'h401);
        wr(A_CTL, 4'hF, 32'h5);
        pc = 32'h302C;
        expect_rise(1);
        step();
        expect_out("fire2_status", 0, A_ACK, 32'h902);
        pc = 32'h3028;
        wr(A_ACK, 4'b0001, 32'h0);
        expect_out("done_status", 0, A_ACK, 32'hC02);
        pc = 32'h302C;
        repeat (5) step();
        expect_out("done_no_fire", 0, A_ACK, 32'hC02);

        // Rearm from DONE; ack coinciding with a match wins
        pc = 32'h3028;
        wr(A_CTL, 4'hF, 32'h1);
        pc = 32'h302C;
        expect_rise(1);
        step();
        wr(A_ACK, 4'b0001, 32'h0);
        pc = 32'h3028;
        expect_out("ack_wins_status", 0, A_ACK, 32'h403);
        pc = 32'h302C;
        expect_rise(1);
        step();
        expect_out("refire_status", 0, A_ACK, 32'h904);

        // Clearing EN while asserted
        wr(A_CTL, 4'b0001, 32'h0);
        expect_out("en_clr_irq",    1, 0, 32'h0);
        expect_out("en_clr_status", 0, A_ACK, 32'h004);
        expect_out("en_clr_ctrl",   0, A_CTL, 32'h0);
        wr(A_TGT, 4'hF, 32'hFFFF_FFFF);
        expect_out("tgt_low_bits", 0, A_TGT, 32'hFFFF_FFFC);
        expect_out("out_of_window", 0, 32'h7f40, 32'h0);
        wr(A_TGT, 4'b0010, 32'h0000_1200);
        expect_out("tgt_byte_merge", 0, A_TGT, 32'hFFFF_12FC);
        wr(32'h7f38, 4'hF, 32'h0);
        expect_out("outside_write_ignored", 0, A_TGT, 32'hFFFF_12FC);

        // Countdown mode
        pc = 32'h3028;
        wr(A_PRE, 4'hF, 32'h4);
        expect_out("preset_rd", 0, A_PRE, 32'h4);
        wr(A_CTL, 4'hF, 32'h3);
        expect_rise(6);
        repeat (6) step();
        expect_out("cd_fire_status", 0, A_ACK, 32'h905);
        wr(A_ACK, 4'b0001, 32'h0);
        expect_rise(5);
        repeat (5) step();
        expect_out("cd_refire_count", 2, 0, 32'h6);
        wr(A_PRE, 4'hF, 32'h0);
        wr(A_ACK, 4'b0001, 32'h0);
        expect_rise(1);
        step();
        expect_out("cd_zero_status", 0, A_ACK, 32'h907);

        // Asynchronous reset while asserted
        #3;
        reset = 1'b1;
        #1;
        cmp("async_rst_irq",   {31'b0, interrupt}, 32'h0);
        cmp("async_rst_count", {24'b0, irq_count}, 32'h0);
        addr = A_CTL;
        #1;
        cmp("async_rst_ctrl", rdata, 32'h0);
        addr = A_TGT;
        #1;
        cmp("async_rst_tgt", rdata, 32'h0);
        addr = A_PRE;
        #1;
        cmp("async_rst_pre", rdata, 32'h0);
        step();
        reset = 1'b0;
        repeat (2) step();
        cmp("pending_irq", 32'(rise_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
